// File: rtl/parking_input_conditioner.sv
// Front end for parking_system_top: synchronises, debounces and edge-detects the
// enter/exit push-buttons, validates each request against slot occupancy and
// emits single-cycle commands or error pulses.
module parking_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NUM_SLOTS       = 3,
  parameter int unsigned SEL_W           = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_enter_raw,
  input  logic                 btn_exit_raw,
  input  logic [SEL_W-1:0]     sel_raw,
  input  logic [NUM_SLOTS-1:0] slot_occupied,
  output logic                 car_enter,
  output logic                 car_exit,
  output logic [SEL_W-1:0]     car_sel,
  output logic                 err_invalid_sel,
  output logic                 err_conflict,
  output logic                 busy
);

  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam int unsigned      BTN_ENTER = 0;
  localparam int unsigned      BTN_EXIT  = 1;
  localparam logic [1:0]       HOLD_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE
  } state_e;

  // Synchronisers
  logic [1:0]       btn_s1_q, btn_s1_d;
  logic [1:0]       btn_s2_q, btn_s2_d;
  logic [SEL_W-1:0] sel_s1_q, sel_s1_d;
  logic [SEL_W-1:0] sel_s2_q, sel_s2_d;

  always_comb begin
    btn_s1_d = {btn_exit_raw, btn_enter_raw};
    btn_s2_d = btn_s1_q;
    sel_s1_d = sel_raw;
    sel_s2_d = sel_s1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      sel_s1_q <= sel_s1_d;
      sel_s2_q <= sel_s2_d;
    end
  end

  // Debounce and rising-edge detect, one lane per button
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       rise;

  always_comb begin
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int unsigned b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (btn_s2_q[b] != deb_q[b]) begin
        // The level only flips once the counter has already sat at its limit,
        // giving a 2+DEBOUNCE_CYCLES edge delay from the first raw sample.
        if (cnt_q[b] == CNT_MAX) begin
          deb_d[b] = btn_s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
    rise = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  // Request classification of the latched request
  logic [SEL_W-1:0] sel_l_q, sel_l_d;
  logic [1:0]       req_q, req_d;
  logic             slot_occ;
  logic             sel_valid;
  logic             req_both;
  logic             is_conflict;
  logic             is_invalid;

  always_comb begin
    slot_occ = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (sel_l_q == SEL_W'(i + 1)) begin
        slot_occ = slot_occupied[i];
      end
    end
    sel_valid   = (sel_l_q != '0) && (32'(sel_l_q) <= NUM_SLOTS);
    req_both    = &req_q;
    is_conflict = req_both |
                  (sel_valid & ((req_q[BTN_ENTER] & slot_occ) |
                                (req_q[BTN_EXIT]  & ~slot_occ)));
    is_invalid  = ~req_both & ~sel_valid;
  end

  // Control FSM and registered outputs
  state_e           state_q, state_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0] car_sel_q, car_sel_d;
  logic             car_enter_q, car_enter_d;
  logic             car_exit_q, car_exit_d;
  logic             err_inv_q, err_inv_d;
  logic             err_conf_q, err_conf_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    sel_l_d     = sel_l_q;
    req_d       = req_q;
    car_sel_d   = car_sel_q;
    car_enter_d = 1'b0;
    car_exit_d  = 1'b0;
    err_inv_d   = 1'b0;
    err_conf_d  = 1'b0;

    unique case (state_q)
      ST_HOLDOFF: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end else if ((deb_q == 2'b00) && (btn_s2_q == 2'b00)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (|rise) begin
          state_d = ST_CHECK;
          sel_l_d = sel_s2_q;
          req_d   = rise;
        end
      end
      ST_CHECK: begin
        // Pulses are registered here so they are visible during ISSUE.
        state_d = ST_ISSUE;
        if (is_conflict) begin
          err_conf_d = 1'b1;
        end else if (is_invalid) begin
          err_inv_d = 1'b1;
        end else begin
          car_sel_d   = sel_l_q;
          car_enter_d = req_q[BTN_ENTER];
          car_exit_d  = req_q[BTN_EXIT];
        end
      end
      ST_ISSUE: begin
        state_d    = ST_HOLDOFF;
        hold_cnt_d = '0;
      end
      default: begin
        state_d    = ST_HOLDOFF;
        hold_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HOLDOFF;
      hold_cnt_q  <= '0;
      sel_l_q     <= '0;
      req_q       <= '0;
      car_sel_q   <= '0;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      err_inv_q   <= 1'b0;
      err_conf_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_l_q     <= sel_l_d;
      req_q       <= req_d;
      car_sel_q   <= car_sel_d;
      car_enter_q <= car_enter_d;
      car_exit_q  <= car_exit_d;
      err_inv_q   <= err_inv_d;
      err_conf_q  <= err_conf_d;
      busy_q      <= busy_d;
    end
  end

  assign car_enter       = car_enter_q;
  assign car_exit        = car_exit_q;
  assign car_sel         = car_sel_q;
  assign err_invalid_sel = err_inv_q;
  assign err_conflict    = err_conf_q;
  assign busy            = busy_q;

endmodule
